// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller with SCAN scheduling.
// Floor calls are latched into a pending register. The car keeps sweeping in
// its current direction while calls remain ahead of it, and reverses only when
// none are left. Travel time and door dwell are cycle counts. Emergency stop
// freezes motion and timers without losing progress. Door-hold and a re-press
// of the current floor both extend the dwell.
module elevator_scan_ctrl #(
   parameter int FLOORS        = 8,
   parameter int POS_W         = $clog2(FLOORS),
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 6,
   parameter int CNT_W         = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLOORS-1:0] floor_req,
   input  logic              door_hold,
   input  logic              estop,
   output logic [POS_W-1:0]  floor_pos,
   output logic              door_open,
   output logic              moving_up,
   output logic              moving_down,
   output logic [FLOORS-1:0] pending,
   output logic              arrive,
   output logic              idle
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MOVE_UP   = 2'd1,
      ST_MOVE_DOWN = 2'd2,
      ST_DOOR      = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
   localparam logic [POS_W-1:0] TOP_POS     = POS_W'(FLOORS - 1);

   state_t            state_r, state_s;
   logic [POS_W-1:0]  pos_r, pos_s;
   logic              dir_up_r, dir_up_s;
   logic [CNT_W-1:0]  tcnt_r, tcnt_s;
   logic [CNT_W-1:0]  dcnt_r, dcnt_s;
   logic              halted_r;
   logic              arrive_r, arrive_s;
   logic [FLOORS-1:0] pending_r, pending_s;
   logic [FLOORS-1:0] clr_s;
   logic              above_s, below_s, here_s, req_here_s;
   logic [POS_W-1:0]  step_pos_s;

   // Status terms derived from the registered pending calls and current floor.
   always_comb begin
      above_s = 1'b0;
      below_s = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (POS_W'(i) > pos_r) begin
            above_s = above_s | pending_r[i];
         end else if (POS_W'(i) < pos_r) begin
            below_s = below_s | pending_r[i];
         end else begin
            above_s = above_s;
         end
      end
      here_s     = pending_r[pos_r];
      req_here_s = floor_req[pos_r];
      if (state_r == ST_MOVE_UP) begin
         step_pos_s = pos_r + POS_W'(1);
      end else begin
         step_pos_s = pos_r - POS_W'(1);
      end
   end

   // Next-state, position, direction and timer logic; everything holds while halted.
   always_comb begin
      state_s  = state_r;
      pos_s    = pos_r;
      dir_up_s = dir_up_r;
      tcnt_s   = tcnt_r;
      dcnt_s   = dcnt_r;
      arrive_s = 1'b0;
      if (halted_r) begin
         state_s = state_r;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (here_s) begin
                  state_s = ST_DOOR;
                  dcnt_s  = '0;
               end else if (above_s) begin
                  state_s  = ST_MOVE_UP;
                  dir_up_s = 1'b1;
                  tcnt_s   = '0;
               end else if (below_s) begin
                  state_s  = ST_MOVE_DOWN;
                  dir_up_s = 1'b0;
                  tcnt_s   = '0;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
               if (tcnt_r == TRAVEL_LAST) begin
                  tcnt_s = '0;
                  // Never step past the shaft ends even if pending was corrupted.
                  if ((state_r == ST_MOVE_UP && pos_r == TOP_POS) ||
                      (state_r == ST_MOVE_DOWN && pos_r == '0)) begin
                     state_s = ST_IDLE;
                  end else begin
                     pos_s    = step_pos_s;
                     arrive_s = 1'b1;
                     if (pending_r[step_pos_s]) begin
                        state_s = ST_DOOR;
                        dcnt_s  = '0;
                     end else begin
                        state_s = state_r;
                     end
                  end
               end else begin
                  tcnt_s = tcnt_r + CNT_W'(1);
               end
            end
            ST_DOOR: begin
               if (door_hold || req_here_s) begin
                  dcnt_s = '0;
               end else if (dcnt_r == DOOR_LAST) begin
                  tcnt_s = '0;
                  if (dir_up_r ? above_s : below_s) begin
                     state_s = dir_up_r ? ST_MOVE_UP : ST_MOVE_DOWN;
                  end else if (dir_up_r ? below_s : above_s) begin
                     state_s  = dir_up_r ? ST_MOVE_DOWN : ST_MOVE_UP;
                     dir_up_s = ~dir_up_r;
                  end else begin
                     state_s = ST_IDLE;
                  end
               end else begin
                  dcnt_s = dcnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Pending calls: capture new requests, clear the served floor (clear wins).
   always_comb begin
      clr_s = '0;
      if (state_r == ST_DOOR || state_s == ST_DOOR) begin
         clr_s[pos_s] = 1'b1;
      end else begin
         clr_s = '0;
      end
      pending_s = (pending_r | floor_req) & ~clr_s;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         pos_r     <= '0;
         dir_up_r  <= 1'b1;
         tcnt_r    <= '0;
         dcnt_r    <= '0;
         halted_r  <= 1'b0;
         arrive_r  <= 1'b0;
         pending_r <= '0;
      end else begin
         state_r   <= state_s;
         pos_r     <= pos_s;
         dir_up_r  <= dir_up_s;
         tcnt_r    <= tcnt_s;
         dcnt_r    <= dcnt_s;
         halted_r  <= estop;
         arrive_r  <= arrive_s;
         pending_r <= pending_s;
      end
   end

   assign floor_pos   = pos_r;
   assign pending     = pending_r;
   assign arrive      = arrive_r;
   assign door_open   = (state_r == ST_DOOR);
   assign moving_up   = (state_r == ST_MOVE_UP) && !halted_r;
   assign moving_down = (state_r == ST_MOVE_DOWN) && !halted_r;
   assign idle        = (state_r == ST_IDLE) && !halted_r;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: a remaining-time behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_elevator_scan_ctrl;

   localparam int FLOORS = 8;
   localparam int TRAVEL = 4;
   localparam int DWELL  = 6;

   localparam int M_REST = 0;
   localparam int M_UP   = 1;
   localparam int M_DOWN = 2;
   localparam int M_DOOR = 3;

   logic              clk;
   logic              rst_n;
   logic [FLOORS-1:0] floor_req;
   logic              door_hold;
   logic              estop;
   logic [2:0]        floor_pos;
   logic              door_open;
   logic              moving_up;
   logic              moving_down;
   logic [FLOORS-1:0] pending;
   logic              arrive;
   logic              idle;

   int n_tests = 0;
   int n_fail  = 0;
   bit checking = 1'b0;

   elevator_scan_ctrl #(
      .FLOORS(FLOORS), .POS_W(3), .TRAVEL_CYCLES(TRAVEL),
      .DOOR_CYCLES(DWELL), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .floor_req(floor_req), .door_hold(door_hold),
      .estop(estop), .floor_pos(floor_pos), .door_open(door_open),
      .moving_up(moving_up), .moving_down(moving_down), .pending(pending),
      .arrive(arrive), .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Car model: counts remaining travel / dwell cycles instead of elapsed ones.
   typedef struct {
      int             mode;
      int             pos;
      bit             up_dir;
      int             travel_left;
      int             dwell_left;
      bit             halted;
      bit             arrive;
      bit [FLOORS-1:0] calls;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.mode = M_REST; r.pos = 0; r.up_dir = 1'b1; r.travel_left = 0;
      r.dwell_left = 0; r.halted = 1'b0; r.arrive = 1'b0; r.calls = '0;
      return r;
   endfunction

   function automatic model_t model_next(model_t c, bit [FLOORS-1:0] req, bit hold, bit es);
      model_t n = c;
      bit any_above = 1'b0;
      bit any_below = 1'b0;
      bit ahead, behind;
      for (int f = 0; f < FLOORS; f++) begin
         if (c.calls[f] && f > c.pos) any_above = 1'b1;
         if (c.calls[f] && f < c.pos) any_below = 1'b1;
      end
      n.halted = es;
      n.arrive = 1'b0;
      if (!c.halted) begin
         if (c.mode == M_REST) begin
            if (c.calls[c.pos]) begin
               n.mode = M_DOOR; n.dwell_left = DWELL;
            end else if (any_above) begin
               n.mode = M_UP; n.up_dir = 1'b1; n.travel_left = TRAVEL;
            end else if (any_below) begin
               n.mode = M_DOWN; n.up_dir = 1'b0; n.travel_left = TRAVEL;
            end
         end else if (c.mode == M_UP || c.mode == M_DOWN) begin
            n.travel_left = c.travel_left - 1;
            if (n.travel_left == 0) begin
               n.pos = (c.mode == M_UP) ? c.pos + 1 : c.pos - 1;
               n.arrive = 1'b1;
               n.travel_left = TRAVEL;
               if (c.calls[n.pos]) begin
                  n.mode = M_DOOR; n.dwell_left = DWELL;
               end
            end
         end else begin
            if (hold || req[c.pos]) begin
               n.dwell_left = DWELL;
            end else begin
               n.dwell_left = c.dwell_left - 1;
               if (n.dwell_left == 0) begin
                  ahead  = c.up_dir ? any_above : any_below;
                  behind = c.up_dir ? any_below : any_above;
                  if (ahead) begin
                     n.mode = c.up_dir ? M_UP : M_DOWN; n.travel_left = TRAVEL;
                  end else if (behind) begin
                     n.up_dir = !c.up_dir;
                     n.mode = n.up_dir ? M_UP : M_DOWN; n.travel_left = TRAVEL;
                  end else begin
                     n.mode = M_REST;
                  end
               end
            end
         end
      end
      n.calls = c.calls | req;
      if (c.mode == M_DOOR || n.mode == M_DOOR) n.calls[n.pos] = 1'b0;
      return n;
   endfunction

   // Advance the model on the same edges as the design.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_next(m, floor_req, door_hold, estop);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output with the model away from the active edge.
   always @(negedge clk) begin
      if (checking) begin
         check("cyc_floor_pos", 64'(floor_pos), 64'(m.pos));
         check("cyc_door_open", 64'(door_open), 64'(m.mode == M_DOOR));
         check("cyc_moving_up", 64'(moving_up), 64'(m.mode == M_UP && !m.halted));
         check("cyc_moving_down", 64'(moving_down), 64'(m.mode == M_DOWN && !m.halted));
         check("cyc_idle", 64'(idle), 64'(m.mode == M_REST && !m.halted));
         check("cyc_pending", 64'(pending), 64'(m.calls));
         check("cyc_arrive", 64'(arrive), 64'(m.arrive));
      end
   end

   // One-edge call pulse; returns just after that edge (E0).
   task automatic call(input logic [FLOORS-1:0] mask);
      floor_req = mask;
      @(negedge clk);
      floor_req = '0;
   endtask

   // Run n cycles, recording the floors where the door opens.
   task automatic run_record(input int n, output int s0, output int s1, output int ns);
      logic prev;
      prev = door_open; ns = 0; s0 = -1; s1 = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (door_open && !prev) begin
            if (ns == 0) s0 = int'(floor_pos);
            else if (ns == 1) s1 = int'(floor_pos);
            ns++;
         end
         prev = door_open;
      end
   endtask

   int cnt, s0, s1, ns;

   initial begin
      floor_req = '0; door_hold = 1'b0; estop = 1'b0; rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checking = 1'b1;
      check("rst_idle", 64'(idle), 64'd1);
      check("rst_pos", 64'(floor_pos), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_door", 64'(door_open), 64'd0);

      // 1: call the current floor -> 6-cycle dwell, then idle
      call(8'h01);
      check("t1_latched", 64'(pending), 64'h01);
      @(negedge clk);
      check("t1_door_e1", 64'(door_open), 64'd1);
      check("t1_clear_e1", 64'(pending), 64'h00);
      cnt = 1;
      repeat (12) begin
         @(negedge clk);
         if (door_open) cnt++;
      end
      check("t1_dwell", 64'(cnt), 64'd6);
      check("t1_idle", 64'(idle), 64'd1);

      // 2: floor 0 -> 3, one floor per 4 cycles
      call(8'h08);
      @(negedge clk);
      check("t2_move_e1", 64'(moving_up), 64'd1);
      repeat (4) @(negedge clk);
      check("t2_pos_e5", 64'(floor_pos), 64'd1);
      check("t2_arr_e5", 64'(arrive), 64'd1);
      @(negedge clk);
      check("t2_arr_e6", 64'(arrive), 64'd0);
      repeat (3) @(negedge clk);
      check("t2_pos_e9", 64'(floor_pos), 64'd2);
      repeat (4) @(negedge clk);
      check("t2_pos_e13", 64'(floor_pos), 64'd3);
      check("t2_door_e13", 64'(door_open), 64'd1);
      repeat (10) @(negedge clk);
      check("t2_idle", 64'(idle), 64'd1);

      // 3: at floor 3 going up, calls 1 and 6 -> serve 6 first, then 1
      call(8'h42);
      run_record(60, s0, s1, ns);
      check("t3_nstops", 64'(ns), 64'd2);
      check("t3_stop0", 64'(s0), 64'd6);
      check("t3_stop1", 64'(s1), 64'd1);
      check("t3_pending", 64'(pending), 64'd0);
      check("t3_pos", 64'(floor_pos), 64'd1);

      // 4a: door_hold for 10 edges -> 16-cycle dwell
      call(8'h02);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (door_open) cnt++;
         door_hold = (i <= 9);
      end
      door_hold = 1'b0;
      check("t4_hold_dwell", 64'(cnt), 64'd16);

      // 4b: re-press current floor on the 4th edge -> 9-cycle dwell, absorbed
      call(8'h02);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (door_open) cnt++;
         if (i == 3) check("t4_absorbed", 64'(pending), 64'd0);
         floor_req = (i == 2) ? 8'h02 : 8'h00;
      end
      floor_req = '0;
      check("t4_repress_dwell", 64'(cnt), 64'd9);
      check("t4_idle", 64'(idle), 64'd1);

      // 5: estop for 7 edges from tcnt=2 toward floor 5
      call(8'h20);
      repeat (3) @(negedge clk);
      estop = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("t5_frozen_move", 64'(moving_up), 64'd0);
         check("t5_frozen_pos", 64'(floor_pos), 64'd1);
      end
      estop = 1'b0;
      @(negedge clk);
      check("t5_e11_pos", 64'(floor_pos), 64'd1);
      check("t5_e11_move", 64'(moving_up), 64'd1);
      @(negedge clk);
      check("t5_e12_pos", 64'(floor_pos), 64'd2);
      check("t5_e12_arr", 64'(arrive), 64'd1);

      // 6: async reset mid-travel
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_pos", 64'(floor_pos), 64'd0);
      check("t6_pending", 64'(pending), 64'd0);
      check("t6_idle", 64'(idle), 64'd1);
      check("t6_moving", 64'(moving_up), 64'd0);
      check("t6_arrive", 64'(arrive), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 7: shaft ends, floors 0 and 7 together, then back to 0
      call(8'h81);
      run_record(50, s0, s1, ns);
      check("t7_nstops", 64'(ns), 64'd2);
      check("t7_stop0", 64'(s0), 64'd0);
      check("t7_stop1", 64'(s1), 64'd7);
      check("t7_top_idle", 64'(idle), 64'd1);
      call(8'h01);
      run_record(45, s0, s1, ns);
      check("t7_down_stops", 64'(ns), 64'd1);
      check("t7_down_floor", 64'(s0), 64'd0);
      check("t7_bottom_idle", 64'(idle), 64'd1);

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
